// File: rtl/owt_rx_pkg.sv
// -----------------------------------------------------------------------------
// owt_rx_pkg
//   Shared types for the OWT receive path: the frame deserializer FSM state
//   and the 2-bit frame error code reported with each frame pulse.
// -----------------------------------------------------------------------------
package owt_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,  // hunting for the sync pattern
    ST_DATA = 2'b01,  // shifting in data bits
    ST_PAR  = 2'b10   // waiting for the even-parity bit
  } owt_rx_st_e;

  typedef enum logic [1:0] {
    ERR_NONE = 2'b00,
    ERR_PAR  = 2'b01,
    ERR_TMO  = 2'b10
  } owt_rx_err_e;

endpackage

// File: rtl/owt_frame_deser.sv
// -----------------------------------------------------------------------------
// owt_frame_deser
//   Sits behind the OWT-mode bit detector. Hunts for a sync pattern in the
//   detected bit stream, then shifts in a DATA_W-bit word (MSB first) and an
//   optional even-parity bit, and reports each finished frame with a single
//   pulse plus error status. A frame in progress is aborted with a timeout
//   error if the gap between bits grows too long.
//
// Ports
//   i_clk       clock
//   i_rst_n     asynchronous active-low reset
//   i_en        block enable; low aborts to IDLE on the next edge, no pulse
//   i_bit_vld   one-cycle pulse, detected bit valid
//   i_bit_data  detected bit value, qualified by i_bit_vld
//   o_frm_vld   one-cycle pulse, frame ended (good or bad)
//   o_frm_data  received word, updated only together with o_frm_vld
//   o_frm_err   00 ok, 01 parity error, 10 timeout; valid with o_frm_vld
//   o_busy      high while a frame is being received (state != IDLE)
// -----------------------------------------------------------------------------
module owt_frame_deser
  import owt_rx_pkg::*;
#(
  parameter int                DATA_W   = 16,
  parameter int                SYNC_W   = 4,
  parameter logic [SYNC_W-1:0] SYNC_PAT = 4'b1010,
  parameter bit                PAR_EN   = 1'b1,
  parameter int                TMO_W    = 12,
  parameter logic [TMO_W-1:0]  TMO_TH   = TMO_W'(2000)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic              i_bit_vld,
  input  logic              i_bit_data,
  output logic              o_frm_vld,
  output logic [DATA_W-1:0] o_frm_data,
  output logic [1:0]        o_frm_err,
  output logic              o_busy
);

  localparam int               CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  owt_rx_st_e        state;
  logic [SYNC_W-1:0] sync_sr;
  logic [DATA_W-1:0] data_sr;
  logic [CNT_W-1:0]  bit_cnt;
  logic [TMO_W-1:0]  tmo_cnt;

  // Shifted views of the sync and data registers with the current bit
  // appended as the new LSB. Widening by one bit keeps the slice legal for
  // any SYNC_W/DATA_W >= 1.
  logic [SYNC_W:0]   sync_ext;
  logic [DATA_W:0]   data_ext;
  logic [SYNC_W-1:0] sync_next;
  logic [DATA_W-1:0] data_next;
  logic              tmo_hit;
  logic              par_bad;

  // NOTE: every always_comb output is assigned unconditionally on every path,
  // so no latch can be inferred.
  always_comb begin
    sync_ext  = {sync_sr, i_bit_data};
    data_ext  = {data_sr, i_bit_data};
    sync_next = sync_ext[SYNC_W-1:0];
    data_next = data_ext[DATA_W-1:0];
    // Fires only in a cycle with no bit: a bit arriving at the threshold wins.
    tmo_hit   = (tmo_cnt == TMO_TH) && !i_bit_vld;
    par_bad   = (^data_sr) ^ i_bit_data;
  end

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= ST_IDLE;
      sync_sr    <= '0;
      data_sr    <= '0;
      bit_cnt    <= '0;
      tmo_cnt    <= '0;
      o_frm_vld  <= 1'b0;
      o_frm_data <= '0;
      o_frm_err  <= ERR_NONE;
      o_busy     <= 1'b0;
    end else begin
      o_frm_vld <= 1'b0;

      if (!i_en) begin
        // Silent abort: the frame outputs keep their last reported values.
        state   <= ST_IDLE;
        o_busy  <= 1'b0;
        sync_sr <= '0;
        bit_cnt <= '0;
        tmo_cnt <= '0;
      end else begin
        unique case (state)
          ST_IDLE: begin
            tmo_cnt <= '0;
            if (i_bit_vld) begin
              if (sync_next == SYNC_PAT) begin
                // The completing sync bit is consumed here, not stored as data.
                state   <= ST_DATA;
                o_busy  <= 1'b1;
                sync_sr <= '0;
                bit_cnt <= '0;
                data_sr <= '0;
              end else begin
                sync_sr <= sync_next;
              end
            end
          end

          ST_DATA: begin
            if (i_bit_vld) begin
              data_sr <= data_next;
              bit_cnt <= bit_cnt + CNT_W'(1);
              tmo_cnt <= '0;
              if (bit_cnt == LAST_BIT) begin
                if (PAR_EN) begin
                  state <= ST_PAR;
                end else begin
                  state      <= ST_IDLE;
                  o_busy     <= 1'b0;
                  bit_cnt    <= '0;
                  o_frm_vld  <= 1'b1;
                  o_frm_data <= data_next;
                  o_frm_err  <= ERR_NONE;
                end
              end
            end else if (tmo_hit) begin
              state      <= ST_IDLE;
              o_busy     <= 1'b0;
              bit_cnt    <= '0;
              tmo_cnt    <= '0;
              o_frm_vld  <= 1'b1;
              o_frm_data <= data_sr;
              o_frm_err  <= ERR_TMO;
            end else if (tmo_cnt != '1) begin
              tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
          end

          ST_PAR: begin
            if (i_bit_vld) begin
              state      <= ST_IDLE;
              o_busy     <= 1'b0;
              bit_cnt    <= '0;
              tmo_cnt    <= '0;
              o_frm_vld  <= 1'b1;
              o_frm_data <= data_sr;
              o_frm_err  <= par_bad ? ERR_PAR : ERR_NONE;
            end else if (tmo_hit) begin
              state      <= ST_IDLE;
              o_busy     <= 1'b0;
              bit_cnt    <= '0;
              tmo_cnt    <= '0;
              o_frm_vld  <= 1'b1;
              o_frm_data <= data_sr;
              o_frm_err  <= ERR_TMO;
            end else if (tmo_cnt != '1) begin
              tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
          end

          default: begin
            state  <= ST_IDLE;
            o_busy <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef ASSERT_ON
  a_tmo_th_nonzero : assert property (@(posedge i_clk) TMO_TH > 0);
  a_sync_fits      : assert property (@(posedge i_clk) SYNC_W <= DATA_W);
  a_single_pulse   : assert property (@(posedge i_clk) disable iff (!i_rst_n)
                                      o_frm_vld |=> !o_frm_vld);
`endif

endmodule

// File: tb/tb_owt_frame_deser.sv
// -----------------------------------------------------------------------------
// tb_owt_frame_deser
//   Self-checking bench for owt_frame_deser. Frames are built from words,
//   parity choices and gap lengths; expected data, error code and pulse cycle
//   come from the frame-format rules, not from the design's state machine.
// -----------------------------------------------------------------------------
module tb_owt_frame_deser;
  import owt_rx_pkg::*;

  localparam int               DATA_W   = 16;
  localparam int               SYNC_W   = 4;
  localparam logic [SYNC_W-1:0] SYNC_PAT = 4'b1010;
  localparam int               TMO_W    = 12;
  localparam int               TMO_TH   = 2000;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              en = 1'b0;
  logic              bit_vld = 1'b0;
  logic              bit_data = 1'b0;
  logic              frm_vld;
  logic [DATA_W-1:0] frm_data;
  logic [1:0]        frm_err;
  logic              busy;

  owt_frame_deser #(
    .DATA_W  (DATA_W),
    .SYNC_W  (SYNC_W),
    .SYNC_PAT(SYNC_PAT),
    .PAR_EN  (1'b1),
    .TMO_W   (TMO_W),
    .TMO_TH  (TMO_W'(TMO_TH))
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_en      (en),
    .i_bit_vld (bit_vld),
    .i_bit_data(bit_data),
    .o_frm_vld (frm_vld),
    .o_frm_data(frm_data),
    .o_frm_err (frm_err),
    .o_busy    (busy)
  );

  always #5 clk = ~clk;

  // Rising-edge count; a pulse registered on edge E is logged with cyc == E.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int                cyc;
    logic [DATA_W-1:0] data;
    logic [1:0]        err;
  } frm_t;

  frm_t mon_q[$];

  always @(posedge clk) begin
    #2;
    if (frm_vld === 1'b1) mon_q.push_back('{cyc, frm_data, frm_err});
  end

  int checks   = 0;
  int failures = 0;
  int bit_cyc  = 0;   // edge on which the most recent bit was captured
  bit stream_q[$];

  // ---------------------------------------------------------------- stimulus
  // All stimulus tasks start and end just after a falling edge.
  task automatic send_bit(input logic b);
    bit_vld  = 1'b1;
    bit_data = b;
    @(negedge clk);
    bit_vld  = 1'b0;
    bit_cyc  = cyc;
  endtask

  task automatic idle(input int n);
    bit_vld = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Sends nbits of v MSB first, with gap idle cycles before each bit.
  task automatic send_seq(input logic [31:0] v, input int nbits, input int gap);
    for (int i = nbits - 1; i >= 0; i--) begin
      idle(gap);
      send_bit(v[i]);
    end
  endtask

  task automatic get_frame(input int budget, output bit got, output frm_t f);
    got = 1'b0;
    f   = '{0, '0, 2'b00};
    for (int i = 0; i < budget && mon_q.size() == 0; i++) @(negedge clk);
    if (mon_q.size() > 0) begin
      f   = mon_q.pop_front();
      got = 1'b1;
    end
  endtask

  function automatic logic [1:0] exp_err(input logic [DATA_W-1:0] w, input logic p);
    return ((^w) ^ p) ? 2'b01 : 2'b00;
  endfunction

  // Index in stream_q at which the sync pattern is first seen, -1 if never.
  function automatic int first_sync();
    int w = 0;
    for (int i = 0; i < stream_q.size(); i++) begin
      w = ((w << 1) | int'(stream_q[i])) & ((1 << SYNC_W) - 1);
      if (w == int'(SYNC_PAT)) return i;
    end
    return -1;
  endfunction

  // Receives a frame expected right now and compares it to the given values.
  task automatic expect_frame(input string name, input logic [DATA_W-1:0] d,
                              input logic [1:0] e, input int at);
    bit   got;
    frm_t f;
    get_frame(TMO_TH + 50, got, f);
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL %s no frame pulse within budget", name);
    end else begin
      checks += 2;
      if (f.data !== d || f.err !== e) begin
        failures++;
        $display("FAIL %s data=%h err=%b expected data=%h err=%b", name, f.data, f.err, d, e);
      end
      if (f.cyc !== at) begin
        failures++;
        $display("FAIL %s pulse at edge %0d expected %0d", name, f.cyc, at);
      end
    end
  endtask

  // ------------------------------------------------------------------ tests
  task automatic test_reset();
    en = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({frm_vld, frm_data, frm_err, busy} !== '0) begin
      failures++;
      $display("FAIL reset_hold vld=%b data=%h err=%b busy=%b expected all zero",
               frm_vld, frm_data, frm_err, busy);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({frm_vld, frm_data, frm_err, busy} !== '0) begin
      failures++;
      $display("FAIL reset_release vld=%b data=%h err=%b busy=%b expected all zero",
               frm_vld, frm_data, frm_err, busy);
    end
  endtask

  task automatic test_good_frame();
    send_seq(32'(SYNC_PAT), SYNC_W, 10);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL good_busy_after_sync busy=%b expected 1", busy);
    end
    send_seq(32'h0000_A5C3, DATA_W, 10);
    send_seq(32'h0, 1, 10);
    expect_frame("good_frame", 16'hA5C3, 2'b00, bit_cyc);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL good_busy_after_frame busy=%b expected 0", busy);
    end
  endtask

  task automatic test_parity_err();
    send_seq(32'(SYNC_PAT), SYNC_W, 10);
    send_seq(32'h0000_A5C3, DATA_W, 10);
    send_seq(32'h1, 1, 10);
    expect_frame("parity_err", 16'hA5C3, 2'b01, bit_cyc);
  endtask

  task automatic test_timeout();
    logic [4:0] part;
    bit         got;
    frm_t       f;
    part = 5'($urandom);
    send_seq(32'(SYNC_PAT), SYNC_W, 3);
    send_seq(32'(part), 5, 3);
    get_frame(TMO_TH + 50, got, f);
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL timeout no frame pulse within budget");
    end else begin
      checks += 3;
      if (f.err !== 2'b10) begin
        failures++;
        $display("FAIL timeout_err err=%b expected 10", f.err);
      end
      if (f.data[4:0] !== part) begin
        failures++;
        $display("FAIL timeout_data data[4:0]=%b expected %b", f.data[4:0], part);
      end
      if (f.cyc !== bit_cyc + TMO_TH + 1) begin
        failures++;
        $display("FAIL timeout_time pulse at edge %0d expected %0d", f.cyc, bit_cyc + TMO_TH + 1);
      end
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL timeout_busy busy=%b expected 0", busy);
    end
  endtask

  // Gaps of exactly TMO_TH idle cycles put a bit on the threshold cycle.
  task automatic test_tmo_edge();
    logic [DATA_W-1:0] w;
    logic              p;
    w = DATA_W'($urandom);
    p = ^w;
    send_seq(32'(SYNC_PAT), SYNC_W, 1);
    for (int i = DATA_W - 1; i >= 0; i--) begin
      idle((i == 12 || i == 3) ? TMO_TH : ((i == 7) ? TMO_TH - 1 : 0));
      send_bit(w[i]);
    end
    idle(TMO_TH);
    send_bit(p);
    expect_frame("tmo_edge", w, 2'b00, bit_cyc);
    idle(5);
    checks++;
    if (mon_q.size() != 0) begin
      failures++;
      $display("FAIL tmo_edge_extra %0d extra pulses expected 0", mon_q.size());
    end
  endtask

  task automatic test_sync_hunt();
    logic [DATA_W-1:0] w;
    w = DATA_W'($urandom);
    send_seq(32'b1101, 4, 2);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL hunt_early busy=%b expected 0 after 1101", busy);
    end
    send_seq(32'b0, 1, 2);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL hunt_found busy=%b expected 1 after fifth bit", busy);
    end
    send_seq(32'(w), DATA_W, 1);
    send_seq(32'(^w), 1, 1);
    expect_frame("sync_hunt", w, 2'b00, bit_cyc);
  endtask

  task automatic test_enable_abort();
    logic [DATA_W-1:0] held;
    held = frm_data;
    send_seq(32'(SYNC_PAT), SYNC_W, 2);
    send_seq(32'h7F, 7, 2);
    idle(2);
    en = 1'b0;
    send_bit(1'b1);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_busy busy=%b expected 0", busy);
    end
    // Bits seen while disabled, including a full sync pattern, are ignored.
    send_seq(32'(SYNC_PAT), SYNC_W, 1);
    idle(5);
    checks += 2;
    if (busy !== 1'b0 || mon_q.size() != 0) begin
      failures++;
      $display("FAIL abort_quiet busy=%b pulses=%0d expected busy=0 pulses=0", busy, mon_q.size());
    end
    if (frm_data !== held) begin
      failures++;
      $display("FAIL abort_hold data=%h expected %h", frm_data, held);
    end
    en = 1'b1;
    idle(1);
    send_seq(32'(SYNC_PAT), SYNC_W, 1);
    send_seq(32'h3C5A, DATA_W, 1);
    send_seq(32'(^16'h3C5A), 1, 1);
    expect_frame("after_abort", 16'h3C5A, 2'b00, bit_cyc);
  endtask

  task automatic test_async_reset();
    send_seq(32'(SYNC_PAT), SYNC_W, 1);
    send_seq(32'h5, 3, 1);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({frm_vld, frm_data, frm_err, busy} !== '0) begin
      failures++;
      $display("FAIL async_reset vld=%b data=%h err=%b busy=%b expected all zero",
               frm_vld, frm_data, frm_err, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    send_seq(32'(SYNC_PAT), SYNC_W, 0);
    send_seq(32'h0F0F, DATA_W, 0);
    send_seq(32'h1, 1, 0);
    expect_frame("after_reset", 16'h0F0F, 2'b01, bit_cyc);
  endtask

  // Random words, gaps, parity and noise prefixes, sent back to back: the
  // first bit of each frame lands in the pulse cycle of the previous one.
  task automatic test_back_to_back();
    frm_t exp_q[$];
    frm_t f;
    bit   got;
    for (int n = 0; n < 10; n++) begin
      logic [DATA_W-1:0] w;
      logic              p;
      int                gap;
      w   = DATA_W'($urandom);
      p   = (($urandom_range(0, 3)) == 0) ? ~(^w) : ^w;
      gap = $urandom_range(0, 4);
      do begin
        int plen;
        stream_q.delete();
        plen = $urandom_range(0, 6);
        for (int i = 0; i < plen; i++) stream_q.push_back(1'($urandom));
        for (int i = SYNC_W - 1; i >= 0; i--) stream_q.push_back(SYNC_PAT[i]);
      end while (first_sync() != stream_q.size() - 1);
      foreach (stream_q[i]) begin
        if (i != 0) idle(gap);
        send_bit(stream_q[i]);
      end
      send_seq(32'(w), DATA_W, gap);
      send_seq(32'(p), 1, gap);
      exp_q.push_back('{bit_cyc, w, exp_err(w, p)});
    end
    idle(5);
    checks++;
    if (mon_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL b2b_count pulses=%0d expected %0d", mon_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      get_frame(1, got, f);
      checks++;
      if (!got || f.cyc !== exp_q[i].cyc || f.data !== exp_q[i].data || f.err !== exp_q[i].err) begin
        failures++;
        $display("FAIL b2b_frame%0d got=%b edge=%0d data=%h err=%b expected edge=%0d data=%h err=%b",
                 i, got, f.cyc, f.data, f.err, exp_q[i].cyc, exp_q[i].data, exp_q[i].err);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_good_frame();
    test_parity_err();
    test_timeout();
    test_tmo_edge();
    test_sync_hunt();
    test_enable_abort();
    test_async_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
